// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// presents the fetched instruction to IF/ID, discarding wrong-path responses.
module if_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             stall_if,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [WIDTH-1:0] if_idpr_now_pc,
    output logic [WIDTH-1:0] if_idpr_pc_plus_4,
    output logic [31:0]      if_idpr_instruction,
    output logic             fetch_invalid,
    output logic [1:0]       dbg_state
);

    // Handshake: a request transfers on any rising edge with imem_req & imem_ready;
    // exactly one imem_rvalid follows each transfer, at least one cycle later.
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             drop_q, drop_d;
    logic [WIDTH-1:0] now_pc_q;
    logic [WIDTH-1:0] pc4_q;
    logic [31:0]      instr_q;
    logic             capture;
    logic [WIDTH-1:0] pc_plus_4;

    assign pc_plus_4 = pc_q + FOUR;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            now_pc_q <= '0;
            pc4_q    <= '0;
            instr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (capture) begin
                now_pc_q <= pc_q;
                pc4_q    <= pc_plus_4;
                instr_q  <= imem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        capture = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            // A response still in flight belongs to the old path and must be eaten.
            if (state_q == S_WAIT) begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end else begin
                    drop_d  = 1'b1;
                end
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            capture = 1'b1;
                            pc_d    = pc_plus_4;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_if) state_d = imem_ready ? S_WAIT : S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        fetch_invalid = (state_q != S_HOLD) | redirect_valid;
        case (state_q)
            S_REQ:   imem_req = ~redirect_valid;
            S_HOLD:  imem_req = ~stall_if & ~redirect_valid;
            default: imem_req = 1'b0;
        endcase
    end

    assign imem_addr           = pc_q;
    assign if_idpr_now_pc      = now_pc_q;
    assign if_idpr_pc_plus_4   = pc4_q;
    assign if_idpr_instruction = instr_q;
    assign dbg_state           = state_q;

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that drives the IF/ID pipeline register. Holds the PC and issues one request at a time to instruction memory over a request/ready + response-valid handshake. Presents the fetched instruction with its PC and PC+4 to IF/ID, and asserts a bubble indication whenever no valid instruction is available. Honors the pipeline stall, and takes branch/jump redirects from later stages, discarding wrong-path fetches.

## Interface
Parameters:
- RESET_PC, default 0: PC loaded on reset.

Ports (`width` is the codebase datapath-width macro from para.v):
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- stall_if  in  1  same stall that holds IF/ID; presented instruction is not consumed while high.
- redirect_valid  in  1  one-cycle pulse: fetch must restart at redirect_pc.
- redirect_pc  in  `width`  redirect target.
- imem_req  out  1  request valid.
- imem_addr  out  `width`  request address; always equals internal pc.
- imem_ready  in  1  request accepted this cycle when imem_req & imem_ready.
- imem_rvalid  in  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rdata  in  32  response instruction.
- if_idpr_now_pc  out  `width`  PC of presented instruction.
- if_idpr_pc_plus_4  out  `width`  now_pc + 4.
- if_idpr_instruction  out  32  presented instruction.
- fetch_invalid  out  1  high when outputs are not a valid instruction; drives IF/ID invalid.

## Operation
- State: pc register, FSM {IDLE, REQ, WAIT, HOLD}, drop flag, output registers.
- Reset: state=IDLE, pc=RESET_PC, drop=0, if_idpr_* = 0. fetch_invalid=1, imem_req=0.
- IDLE: lasts exactly one cycle after reset, then REQ.
- REQ: imem_req = ~redirect_valid. On acceptance, go to WAIT.
- WAIT: imem_req=0. On imem_rvalid with drop=0 and no redirect in the same cycle:
  - capture now_pc=pc, pc_plus_4=pc+4, instruction=imem_rdata;
  - pc <= pc+4;
  - go to HOLD.
- HOLD: outputs valid. imem_req = ~stall_if & ~redirect_valid, for the already-incremented pc.
  - ~stall_if and accepted: go to WAIT.
  - ~stall_if and not accepted: go to REQ.
  - stall_if: stay in HOLD; outputs stable.
- fetch_invalid = (state != HOLD) | redirect_valid. This is combinational.
- Redirect has priority over stall and all other events. It always sets pc <= redirect_pc. Per state:
  - IDLE/REQ: go to (or stay in) REQ. No request is accepted in the redirect cycle.
  - WAIT without imem_rvalid: set drop=1, stay in WAIT.
  - WAIT with imem_rvalid in the same cycle: discard the response, go to REQ, leave drop=0.
  - HOLD: go to REQ. Output registers keep their contents but fetch_invalid=1.
  - A redirect while drop=1 just updates pc again.
- WAIT with drop=1 and imem_rvalid: discard the response, clear drop, go to REQ.
- imem_rvalid outside WAIT: ignored.
- Arithmetic: pc+4 is computed modulo 2^`width`; all-ones-3 wraps to 0. No alignment checks.
- Reset mid-transaction: return to the reset state immediately. A response to a request accepted before reset is not guarded against; the memory is reset together with this block.

## Timing
- Reset released at cycle 0 (IDLE). REQ is at cycle 1.
- With imem_ready=1 and rvalid one cycle after acceptance: WAIT at cycle 2, HOLD at cycle 3 with fetch_invalid=0.
- Steady state, no stall, single-cycle memory: HOLD/WAIT alternate, giving one instruction every 2 cycles. fetch_invalid is high on WAIT cycles (IF/ID loads a bubble).
- Consumption is defined as a rising edge in HOLD with stall_if=0 and redirect_valid=0. Each instruction is presented until consumed, then never again.
- Redirect to first valid target instruction: minimum 3 cycles (REQ, WAIT, HOLD) with single-cycle memory. It is longer if a drop is pending.

## Test plan
- Reset, RESET_PC=0x100, ideal memory returning rdata=addr: after 3 cycles, now_pc=0x100, pc_plus_4=0x104, instruction=0x100. Next valid outputs show 0x104, then 0x108; fetch_invalid alternates 0/1.
- stall_if held high 5 cycles in HOLD at pc 0x104: outputs frozen, imem_req=0, fetch_invalid=0. After release, next instruction is 0x108 with no skip or duplicate.
- imem_ready low 4 cycles in REQ: imem_req stays high, imem_addr stable, fetch_invalid=1. Capture occurs 2 cycles after ready rises.
- Redirect to 0x200 while in WAIT (response due in 3 cycles): late response is discarded. First valid output is now_pc=0x200, pc_plus_4=0x204.
- Redirect to 0x300 in HOLD with stall_if=1: fetch_invalid=1 in that cycle. Next valid output is 0x300; the stalled instruction is never re-presented.
- RESET_PC = all-ones minus 3 (0xFFFF_FFFC for 32-bit): first pc_plus_4=0, and the next fetch address is 0.
